// File: rtl/uart_slv_pkg.sv
// Shared register map, response codes and status-bit layout for the AXI-lite UART slave.
// The optional error responses are built in when UART_SLV_ERR_EN is defined.
package uart_slv_pkg;

    localparam logic [1:0] REG_RX_DATA = 2'd0;
    localparam logic [1:0] REG_RX_STAT = 2'd1;
    localparam logic [1:0] REG_TX_STAT = 2'd2;
    localparam logic [1:0] REG_TX_DATA = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int RX_STAT_NEMPTY_BIT = 0;
    localparam int RX_STAT_CNT_LSB    = 1;
    localparam int RX_STAT_CNT_MSB    = 3;
    localparam int TX_STAT_NFULL_BIT  = 0;

    // Occupancy field is only 3 bits wide, so deeper FIFOs report 7.
    function automatic logic [2:0] sat_cnt3(input logic [31:0] c);
        return (c > 32'd7) ? 3'd7 : c[2:0];
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with power-of-2 depth. A push into a full FIFO is accepted only when a
// pop happens in the same cycle; a pop of an empty FIFO is ignored.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign head  = mem_q[rd_ptr_q];
    assign count = cnt_q;

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop)
            cnt_d = cnt_q + CW'(1);
        else if (!do_push && do_pop)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/axi_lite_uart_slave.sv
// AXI4-lite register front end for the UART byte streams: RX data/status, TX status/data.
// Define UART_SLV_ERR_EN to answer illegal or dropped accesses with SLVERR.
module axi_lite_uart_slave
    import uart_slv_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              axi_awvalid,
    output logic              axi_awready,
    input  logic [ADDR_W-1:0] axi_awaddr,
    input  logic [2:0]        axi_awprot,
    input  logic              axi_wvalid,
    output logic              axi_wready,
    input  logic [31:0]       axi_wdata,
    input  logic [3:0]        axi_wstrb,
    output logic              axi_bvalid,
    input  logic              axi_bready,
    output logic [1:0]        axi_bresp,
    input  logic              axi_arvalid,
    output logic              axi_arready,
    input  logic [ADDR_W-1:0] axi_araddr,
    input  logic [2:0]        axi_arprot,
    output logic              axi_rvalid,
    input  logic              axi_rready,
    output logic [31:0]       axi_rdata,
    output logic [1:0]        axi_rresp,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [7:0]        rx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          en_q, en_d;
    logic          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   rd_word;
    logic          rd_err, wr_err;
    logic          wr_hs, ar_hs;
    logic [1:0]    wr_addr, rd_addr;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]    rx_head;
    logic [CW-1:0] rx_count, tx_count;
    logic          unused_sig;

    assign unused_sig = ^{axi_awaddr, axi_araddr, axi_awprot, axi_arprot,
                          axi_wdata, axi_wstrb, tx_count};

    assign wr_addr = axi_awaddr[3:2];
    assign rd_addr = axi_araddr[3:2];

    // en_q keeps every ready low while reset is asserted and for the first cycle after.
    assign wr_hs       = en_q && axi_awvalid && axi_wvalid && !bvalid_q;
    assign axi_awready = wr_hs;
    assign axi_wready  = wr_hs;
    assign axi_arready = en_q && (!rvalid_q || axi_rready);
    assign ar_hs       = axi_arvalid && axi_arready;

    assign rx_pop   = ar_hs && (rd_addr == REG_RX_DATA) && !rx_empty;
    assign rx_ready = en_q && (!rx_full || rx_pop);
    assign rx_push  = rx_valid && rx_ready;

    assign tx_valid = !tx_empty;
    assign tx_pop   = tx_valid && tx_ready;
    assign tx_push  = wr_hs && (wr_addr == REG_TX_DATA) && axi_wstrb[0];

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .push_data(rx_data), .pop(rx_pop),
        .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push), .push_data(axi_wdata[7:0]), .pop(tx_pop),
        .head(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    // Status reflects occupancy before any push/pop in the handshake cycle.
    always_comb begin
        rd_word = '0;
        case (rd_addr)
            REG_RX_DATA: if (!rx_empty) rd_word[7:0] = rx_head;
            REG_RX_STAT: begin
                rd_word[RX_STAT_NEMPTY_BIT] = !rx_empty;
                rd_word[RX_STAT_CNT_MSB:RX_STAT_CNT_LSB] = sat_cnt3(32'(rx_count));
            end
            REG_TX_STAT: rd_word[TX_STAT_NFULL_BIT] = !tx_full;
            default: ;
        endcase
`ifdef UART_SLV_ERR_EN
        rd_err = ((rd_addr == REG_RX_DATA) && rx_empty) || (rd_addr == REG_TX_DATA);
        wr_err = (wr_addr != REG_TX_DATA) || !axi_wstrb[0] || (tx_full && !tx_pop);
`else
        rd_err = 1'b0;
        wr_err = 1'b0;
`endif
    end

    always_comb begin
        en_d     = 1'b1;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (wr_hs) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
        end else if (axi_bready) begin
            bvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
            rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q     <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            en_q     <= en_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
        end
    end

    assign axi_bvalid = bvalid_q;
    assign axi_bresp  = bresp_q;
    assign axi_rvalid = rvalid_q;
    assign axi_rresp  = rresp_q;
    assign axi_rdata  = rdata_q;

endmodule

// File: tb/tb_axi_lite_uart_slave.sv
// Directed bench for axi_lite_uart_slave; read/write responses are checked against queued expectations.
module tb_axi_lite_uart_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
    logic [31:0] axi_awaddr, axi_araddr, axi_wdata, axi_rdata;
    logic [2:0]  axi_awprot, axi_arprot;
    logic [3:0]  axi_wstrb;
    logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic [1:0]  axi_bresp, axi_rresp;
    logic        rx_valid, rx_ready, tx_valid, tx_ready;
    logic [7:0]  rx_data, tx_data;

    int checks = 0;
    int failures = 0;

    logic [31:0] rd_q[$];
    logic [1:0]  rresp_q[$];
    logic [1:0]  bresp_q[$];
    logic [7:0]  tx_q[$];

`ifdef UART_SLV_ERR_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif

    axi_lite_uart_slave #(.FIFO_DEPTH(4), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awprot(axi_awprot), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] ed, input logic [1:0] er,
                      input string tag);
        logic hs;
        logic [31:0] e;
        logic [1:0] r;
        rd_q.push_back(ed);
        rresp_q.push_back(er);
        @(negedge clk);
        axi_arvalid = 1'b1; axi_araddr = addr; axi_rready = 1'b1; hs = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1 hs = axi_arready;
            @(posedge clk);
            if (hs) break;
        end
        #1 axi_arvalid = 1'b0;
        e = rd_q.pop_front();
        r = rresp_q.pop_front();
        if (!hs) chk({tag, "_ar_timeout"}, 32'd0, 32'd1);
        else begin
            chk({tag, "_rvalid"}, {31'd0, axi_rvalid}, 32'd1);
            chk({tag, "_rdata"}, axi_rdata, e);
            chk({tag, "_rresp"}, {30'd0, axi_rresp}, {30'd0, r});
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input logic [1:0] er, input string tag);
        logic hs;
        logic [1:0] r;
        bresp_q.push_back(er);
        @(negedge clk);
        axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_awaddr = addr; axi_wdata = data;
        axi_wstrb = strb; axi_bready = 1'b1; hs = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1 hs = axi_awready && axi_wready;
            @(posedge clk);
            if (hs) break;
        end
        #1 axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        r = bresp_q.pop_front();
        if (!hs) chk({tag, "_aw_timeout"}, 32'd0, 32'd1);
        else begin
            chk({tag, "_bvalid"}, {31'd0, axi_bvalid}, 32'd1);
            chk({tag, "_bresp"}, {30'd0, axi_bresp}, {30'd0, r});
        end
    endtask

    task automatic rx_send(input logic [7:0] b);
        logic hs;
        @(negedge clk);
        rx_valid = 1'b1; rx_data = b; hs = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1 hs = rx_ready;
            @(posedge clk);
            if (hs) break;
        end
        #1 rx_valid = 1'b0;
        if (!hs) chk("rx_send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        axi_awvalid = 0; axi_awaddr = 0; axi_awprot = 0; axi_wvalid = 0; axi_wdata = 0;
        axi_wstrb = 0; axi_bready = 0; axi_arvalid = 0; axi_araddr = 0; axi_arprot = 0;
        axi_rready = 0; rx_valid = 0; rx_data = 0; tx_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", {31'd0, axi_arready}, 32'd0);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_bvalid", {31'd0, axi_bvalid}, 32'd0);
        chk("rst_rvalid", {31'd0, axi_rvalid}, 32'd0);
        chk("rst_rdata", axi_rdata, 32'd0);
        chk("rst_resps", {28'd0, axi_bresp, axi_rresp}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        rd(32'h4, 32'h0, 2'b00, "rxstat_idle");
        rd(32'h8, 32'h1, 2'b00, "txstat_idle");

        rx_send(8'h41);
        rx_send(8'h42);
        rd(32'h4, 32'h5, 2'b00, "rxstat_two");
        rd(32'h0, 32'h41, 2'b00, "rxdata_a");
        rd(32'h0, 32'h42, 2'b00, "rxdata_b");
        rd(32'h4, 32'h0, 2'b00, "rxstat_drained");

        tx_ready = 1'b0;
        tx_q.push_back(8'h5A);
        wr(32'hC, 32'h0000005A, 4'h1, 2'b00, "tx_wr");
        chk("tx_valid_after_wr", {31'd0, tx_valid}, 32'd1);
        chk("tx_data_after_wr", {24'd0, tx_data}, {24'd0, tx_q.pop_front()});
        @(negedge clk) tx_ready = 1'b1;
        @(posedge clk); #1;
        chk("tx_valid_after_pop", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        rd(32'h0, 32'h0, ERR, "rxdata_empty");

        // Fill RX, then pop with a 5th byte waiting: it must enter on the pop cycle.
        for (int i = 0; i < 4; i++) rx_send(8'h10 + 8'(i));
        #1 chk("rx_ready_full", {31'd0, rx_ready}, 32'd0);
        rd(32'h4, 32'h9, 2'b00, "rxstat_full");
        @(negedge clk) begin rx_valid = 1'b1; rx_data = 8'h14; end
        rd(32'h0, 32'h10, 2'b00, "rx_pop_full");
        rx_valid = 1'b0;
        for (int i = 1; i < 5; i++) rd(32'h0, 32'h10 + 32'(i), 2'b00, "rx_after_full");
        rd(32'h4, 32'h0, 2'b00, "rxstat_after_full");

        // Back-pressure on R: data must hold while rready is low.
        rx_send(8'h77);
        rd_q.push_back(32'h77);
        @(negedge clk) begin axi_arvalid = 1'b1; axi_araddr = 32'h0; axi_rready = 1'b0; end
        #1 chk("bp_arready_first", {31'd0, axi_arready}, 32'd1);
        @(posedge clk); #1;
        axi_araddr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            chk("bp_rvalid_hold", {31'd0, axi_rvalid}, 32'd1);
            chk("bp_rdata_hold", axi_rdata, rd_q[0]);
            chk("bp_arready_low", {31'd0, axi_arready}, 32'd0);
            @(posedge clk); #1;
        end
        void'(rd_q.pop_front());
        @(negedge clk) axi_rready = 1'b1;
        #1 chk("bp_release_arready", {31'd0, axi_arready}, 32'd1);
        @(posedge clk); #1;
        axi_arvalid = 1'b0;
        chk("bp_next_rvalid", {31'd0, axi_rvalid}, 32'd1);
        chk("bp_next_rdata", axi_rdata, 32'h1);

        // Fill TX with the transmitter stalled; the overflow byte is dropped.
        tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tx_q.push_back(8'(i));
            wr(32'hC, 32'(i), 4'h1, 2'b00, "tx_fill");
        end
        rd(32'h8, 32'h0, 2'b00, "txstat_full");
        wr(32'hC, 32'h99, 4'h1, ERR, "tx_overflow");
        @(negedge clk) tx_ready = 1'b1;
        #1;
        while (tx_q.size() > 0) begin
            chk("tx_drain_valid", {31'd0, tx_valid}, 32'd1);
            chk("tx_drain_data", {24'd0, tx_data}, {24'd0, tx_q.pop_front()});
            @(posedge clk); #1;
        end
        chk("tx_drain_empty", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        wr(32'hC, 32'h55, 4'h0, ERR, "tx_nostrb");
        wr(32'h0, 32'h66, 4'h1, ERR, "wr_ro");
        chk("tx_no_push", {31'd0, tx_valid}, 32'd0);
        rd(32'hC, 32'h0, ERR, "rd_txdata");

        // Reset while a read response is pending.
        rx_send(8'h33);
        @(negedge clk) begin axi_arvalid = 1'b1; axi_araddr = 32'h4; axi_rready = 1'b0; end
        @(posedge clk); #1;
        axi_arvalid = 1'b0;
        chk("midrst_rvalid_pre", {31'd0, axi_rvalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_rvalid", {31'd0, axi_rvalid}, 32'd0);
        chk("midrst_rdata", axi_rdata, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        rd(32'h4, 32'h0, 2'b00, "midrst_rx_lost");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
